// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared declarations for the instruction-cache stage-1 array.
//  - Default geometry and the widths derived from it.
//  - tag_t / line_t / idx_t / way_t typedefs for the default geometry.
//  - Invalidate-walk FSM state encoding.
//  - Tree-PLRU helpers plru_victim() / plru_touch().
// The PLRU helpers work on a fixed maximum tree (up to 64 ways).
// Callers pass log2(ways) and cast the operands to and from the wide vectors.
// Tree layout is heap order: node 0 is the root and node n has children
// 2n+1 (lower half) and 2n+2 (upper half).
// A node bit of 0 steers the victim search into the lower half.
// ---------------------------------------------------------------------------
package icache_pkg;

  localparam int unsigned ICACHE_ADDR_WIDTH = 32;
  localparam int unsigned ICACHE_NUM_SETS   = 64;
  localparam int unsigned ICACHE_NUM_WAYS   = 4;
  localparam int unsigned ICACHE_LINE_WIDTH = 128;

  localparam int unsigned ICACHE_OFF_W = $clog2(ICACHE_LINE_WIDTH / 8);
  localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_NUM_SETS);
  localparam int unsigned ICACHE_WAY_W = $clog2(ICACHE_NUM_WAYS);
  localparam int unsigned ICACHE_TAG_W = ICACHE_ADDR_WIDTH - ICACHE_IDX_W - ICACHE_OFF_W;

  typedef logic [ICACHE_TAG_W-1:0]      tag_t;
  typedef logic [ICACHE_LINE_WIDTH-1:0] line_t;
  typedef logic [ICACHE_IDX_W-1:0]      idx_t;
  typedef logic [ICACHE_WAY_W-1:0]      way_t;

  // Largest tree the helpers handle: 2^6 ways, 63 node bits.
  localparam int unsigned PLRU_MAX_LG = 6;
  localparam int unsigned PLRU_MAX_W  = 63;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_INV  = 1'b1
  } inv_state_e;

  // Follow node bits from the root; returns the way index in the low lg bits.
  function automatic logic [PLRU_MAX_LG-1:0] plru_victim(
    input logic [PLRU_MAX_W-1:0] bits,
    input int unsigned           lg
  );
    logic [PLRU_MAX_LG-1:0] way;
    logic [5:0]             node;
    logic                   b;
    way  = '0;
    node = 6'd0;
    for (int unsigned l = 0; l < PLRU_MAX_LG; l++) begin
      if (l < lg) begin
        b    = bits[node];
        way  = {way[PLRU_MAX_LG-2:0], b};
        node = 6'(({1'b0, node} << 3'd1) + 7'd1 + {6'd0, b});
      end else begin
        node = node;
      end
    end
    return way;
  endfunction

  // Make every node on the path to 'way' point into the opposite half.
  function automatic logic [PLRU_MAX_W-1:0] plru_touch(
    input logic [PLRU_MAX_W-1:0]  bits,
    input logic [PLRU_MAX_LG-1:0] way,
    input int unsigned            lg
  );
    logic [PLRU_MAX_W-1:0]  nb;
    logic [PLRU_MAX_LG-1:0] wl;
    logic [5:0]             node;
    logic                   b;
    nb   = bits;
    node = 6'd0;
    // Left-align the way so its MSB (root decision) is always at the top.
    wl   = way << (PLRU_MAX_LG - lg);
    for (int unsigned l = 0; l < PLRU_MAX_LG; l++) begin
      if (l < lg) begin
        b        = wl[PLRU_MAX_LG-1];
        wl       = wl << 3'd1;
        nb[node] = ~b;
        node     = 6'(({1'b0, node} << 3'd1) + 7'd1 + {6'd0, b});
      end else begin
        node = node;
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/icache_plru_tree.sv
// ---------------------------------------------------------------------------
// icache_plru_tree
// Combinational tree-PLRU logic for a single set.
// Ports:
//  plru_i       in   NUM_WAYS-1  current node bits of the set
//  touch_way_i  in   log2(ways)  way being made most-recently-used
//  victim_o     out  log2(ways)  way the current bits point at
//  plru_next_o  out  NUM_WAYS-1  node bits after touching touch_way_i
// ---------------------------------------------------------------------------
module icache_plru_tree
  import icache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = ICACHE_NUM_WAYS
) (
  input  logic [NUM_WAYS-2:0]         plru_i,
  input  logic [$clog2(NUM_WAYS)-1:0] touch_way_i,
  output logic [$clog2(NUM_WAYS)-1:0] victim_o,
  output logic [NUM_WAYS-2:0]         plru_next_o
);

  localparam int unsigned WAY_W  = $clog2(NUM_WAYS);
  localparam int unsigned PLRU_W = NUM_WAYS - 1;

  // Victim lookup and touch update, widened to the helper size and narrowed back.
  always_comb begin
    victim_o    = WAY_W'(plru_victim(PLRU_MAX_W'(plru_i), WAY_W));
    plru_next_o = PLRU_W'(plru_touch(PLRU_MAX_W'(plru_i), PLRU_MAX_LG'(touch_way_i), WAY_W));
  end

endmodule

// File: rtl/icache_s1_array.sv
// ---------------------------------------------------------------------------
// icache_s1_array
// Stage 1 of the instruction cache.
// It is a set-associative tag/data/valid array with tree-PLRU replacement.
// An accepted fetch PC reads every way of its set into the tos2_* registers
// (latency 1).
// Stage-2 hit reports touch the PLRU.
// Refills pick a victim internally: the lowest invalid way, otherwise the
// PLRU way.
// inv_i starts a walk that clears valid and PLRU bits one set per cycle.
// Optional feature macro: ICACHE_REFILL_FWD_EN. When it is defined, a read of
// the set being refilled returns the new line in the refilled way. When it is
// not defined, the read returns the pre-write contents.
// Ports:
//  clk, rst                 clock, synchronous active-high reset
//  stall_i / flush_i        hold tos2_* / kill tos2_valid_o
//  inv_i                    start invalidate-all walk (ignored while busy)
//  pc_i, pc_valid_i         fetch request; pc_ready_o = !stall_i && !busy_o
//  hit_valid_i/set/way      stage-2 hit report (PLRU touch)
//  refill_valid_i/set/tag/data  line write; refill_way_o names the way written
//  busy_o                   invalidate walk active
//  tos2_valid_o/pc/data/tag/vbit  registered stage-2 payload
// ---------------------------------------------------------------------------
module icache_s1_array
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ICACHE_ADDR_WIDTH,
  parameter int unsigned NUM_SETS   = ICACHE_NUM_SETS,
  parameter int unsigned NUM_WAYS   = ICACHE_NUM_WAYS,
  parameter int unsigned LINE_WIDTH = ICACHE_LINE_WIDTH
) (
  input  logic                                                            clk,
  input  logic                                                            rst,
  input  logic                                                            stall_i,
  input  logic                                                            flush_i,
  input  logic                                                            inv_i,
  input  logic [ADDR_WIDTH-1:0]                                           pc_i,
  input  logic                                                            pc_valid_i,
  output logic                                                            pc_ready_o,
  input  logic                                                            hit_valid_i,
  input  logic [$clog2(NUM_SETS)-1:0]                                     hit_set_i,
  input  logic [$clog2(NUM_WAYS)-1:0]                                     hit_way_i,
  input  logic                                                            refill_valid_i,
  input  logic [$clog2(NUM_SETS)-1:0]                                     refill_set_i,
  input  logic [ADDR_WIDTH-$clog2(NUM_SETS)-$clog2(LINE_WIDTH/8)-1:0]     refill_tag_i,
  input  logic [LINE_WIDTH-1:0]                                           refill_data_i,
  output logic [$clog2(NUM_WAYS)-1:0]                                     refill_way_o,
  output logic                                                            busy_o,
  output logic                                                            tos2_valid_o,
  output logic [ADDR_WIDTH-1:0]                                           tos2_pc_o,
  output logic [NUM_WAYS-1:0][LINE_WIDTH-1:0]                             tos2_data_o,
  output logic [NUM_WAYS-1:0][ADDR_WIDTH-$clog2(NUM_SETS)-$clog2(LINE_WIDTH/8)-1:0] tos2_tag_o,
  output logic [NUM_WAYS-1:0]                                             tos2_vbit_o
);

  localparam int unsigned OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned WAY_W  = $clog2(NUM_WAYS);
  localparam int unsigned TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int unsigned PLRU_W = NUM_WAYS - 1;

  // Flop-based arrays so that reset clears everything in one cycle.
  logic [NUM_WAYS-1:0][TAG_W-1:0]      tag_r   [NUM_SETS];
  logic [NUM_WAYS-1:0][LINE_WIDTH-1:0] data_r  [NUM_SETS];
  logic [NUM_WAYS-1:0]                 valid_r [NUM_SETS];
  logic [PLRU_W-1:0]                   plru_r  [NUM_SETS];

  inv_state_e       state_r;
  inv_state_e       state_nx_s;
  logic [IDX_W-1:0] inv_cnt_r;
  logic             busy_s;

  logic             accept_s;
  logic [IDX_W-1:0] rd_set_s;
  logic             refill_en_s;
  logic             hit_en_s;
  logic             fwd_s;

  logic [WAY_W-1:0]  ref_victim_s;
  logic [WAY_W-1:0]  refill_way_s;
  logic [PLRU_W-1:0] ref_plru_next_s;
  logic [PLRU_W-1:0] hit_plru_in_s;
  logic [PLRU_W-1:0] hit_plru_next_s;
  logic [WAY_W-1:0]  hit_victim_unused_s;

  logic [NUM_WAYS-1:0][TAG_W-1:0]      rd_tag_s;
  logic [NUM_WAYS-1:0][LINE_WIDTH-1:0] rd_data_s;
  logic [NUM_WAYS-1:0]                 rd_vbit_s;

  // The miss handler halts on busy_o, so hits and refills are dropped during a walk.
  assign refill_en_s  = refill_valid_i && !busy_s;
  assign hit_en_s     = hit_valid_i && !busy_s;
  assign pc_ready_o   = !stall_i && !busy_s;
  assign accept_s     = pc_valid_i && pc_ready_o;
  assign rd_set_s     = pc_i[OFF_W +: IDX_W];
  assign busy_o       = busy_s;
  assign refill_way_o = refill_way_s;

`ifdef ICACHE_REFILL_FWD_EN
  assign fwd_s = refill_en_s && (refill_set_i == rd_set_s);
`else
  assign fwd_s = 1'b0;
`endif

  // ---------------- invalidate-walk FSM ----------------

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; inv_i is only looked at in IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: state_nx_s = inv_i ? ST_INV : ST_IDLE;
      ST_INV:  state_nx_s = (inv_cnt_r == IDX_W'(NUM_SETS - 1)) ? ST_IDLE : ST_INV;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_s = (state_r == ST_INV);
  end

  // Walk counter; it wraps to zero on the last set, which is also the exit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_cnt_r <= '0;
    end else if (busy_s) begin
      inv_cnt_r <= inv_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      inv_cnt_r <= '0;
    end
  end

  // ---------------- replacement ----------------

  // The refill port uses the victim and touches the way it actually writes.
  icache_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_refill (
    .plru_i      (plru_r[refill_set_i]),
    .touch_way_i (refill_way_s),
    .victim_o    (ref_victim_s),
    .plru_next_o (ref_plru_next_s)
  );

  // A hit to the set being refilled builds on the refill touch, so the hit way ends MRU.
  assign hit_plru_in_s = (refill_en_s && (hit_set_i == refill_set_i)) ?
                         ref_plru_next_s : plru_r[hit_set_i];

  // The hit port only needs the touch result.
  icache_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_hit (
    .plru_i      (hit_plru_in_s),
    .touch_way_i (hit_way_i),
    .victim_o    (hit_victim_unused_s),
    .plru_next_o (hit_plru_next_s)
  );

  // Victim choice: the lowest-index invalid way if there is one, else the PLRU way.
  always_comb begin
    refill_way_s = ref_victim_s;
    // Scan downwards so the lowest invalid index is the last assignment.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      refill_way_s = (!valid_r[refill_set_i][w]) ? WAY_W'(w) : refill_way_s;
    end
  end

  // ---------------- array state ----------------

  // Array updates: reset clear, walk clear, refill write and PLRU touches.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        tag_r[s]   <= '0;
        data_r[s]  <= '0;
        valid_r[s] <= '0;
        plru_r[s]  <= '0;
      end
    end else if (busy_s) begin
      valid_r[inv_cnt_r] <= '0;
      plru_r[inv_cnt_r]  <= '0;
    end else begin
      if (refill_en_s) begin
        tag_r[refill_set_i][refill_way_s]   <= refill_tag_i;
        data_r[refill_set_i][refill_way_s]  <= refill_data_i;
        valid_r[refill_set_i][refill_way_s] <= 1'b1;
        plru_r[refill_set_i]                <= ref_plru_next_s;
      end else begin
        plru_r[refill_set_i] <= plru_r[refill_set_i];
      end
      // Issued after the refill write so a same-set hit overrides it.
      if (hit_en_s) begin
        plru_r[hit_set_i] <= hit_plru_next_s;
      end else begin
        plru_r[hit_set_i] <= plru_r[hit_set_i];
      end
    end
  end

  // ---------------- read path ----------------

  // Read mux: the indexed set, with optional forwarding of a same-cycle refill.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (fwd_s && (refill_way_s == WAY_W'(w))) begin
        rd_tag_s[w]  = refill_tag_i;
        rd_data_s[w] = refill_data_i;
        rd_vbit_s[w] = 1'b1;
      end else begin
        rd_tag_s[w]  = tag_r[rd_set_s][w];
        rd_data_s[w] = data_r[rd_set_s][w];
        rd_vbit_s[w] = valid_r[rd_set_s][w];
      end
    end
  end

  // Stage-2 registers. Flush beats stall, and stall beats accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      tos2_valid_o <= 1'b0;
      tos2_pc_o    <= '0;
      tos2_data_o  <= '0;
      tos2_tag_o   <= '0;
      tos2_vbit_o  <= '0;
    end else if (flush_i) begin
      tos2_valid_o <= 1'b0;
    end else if (stall_i) begin
      tos2_valid_o <= tos2_valid_o;
    end else if (accept_s) begin
      tos2_valid_o <= 1'b1;
      tos2_pc_o    <= pc_i;
      tos2_data_o  <= rd_data_s;
      tos2_tag_o   <= rd_tag_s;
      tos2_vbit_o  <= rd_vbit_s;
    end else begin
      tos2_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_s1_array.sv
// Directed bench for icache_s1_array in its default geometry:
// 32-bit PC, 64 sets, 4 ways, 128-bit lines, which gives tag = pc[31:10] and set = pc[9:4].
module tb_icache_s1_array;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall_i, flush_i, inv_i;
  logic [31:0]        pc_i;
  logic               pc_valid_i, pc_ready_o;
  logic               hit_valid_i;
  logic [5:0]         hit_set_i;
  logic [1:0]         hit_way_i;
  logic               refill_valid_i;
  logic [5:0]         refill_set_i;
  logic [21:0]        refill_tag_i;
  logic [127:0]       refill_data_i;
  logic [1:0]         refill_way_o;
  logic               busy_o, tos2_valid_o;
  logic [31:0]        tos2_pc_o;
  logic [3:0][127:0]  tos2_data_o;
  logic [3:0][21:0]   tos2_tag_o;
  logic [3:0]         tos2_vbit_o;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt;

  localparam logic [21:0] TA = 22'h00A11;
  localparam logic [21:0] TB = 22'h00B22;
  localparam logic [21:0] TC = 22'h00C33;
  localparam logic [21:0] TD = 22'h00D44;
  localparam logic [21:0] TE = 22'h00E55;
  localparam logic [21:0] TF = 22'h00F66;

  icache_s1_array dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .inv_i(inv_i),
    .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .hit_valid_i(hit_valid_i), .hit_set_i(hit_set_i), .hit_way_i(hit_way_i),
    .refill_valid_i(refill_valid_i), .refill_set_i(refill_set_i),
    .refill_tag_i(refill_tag_i), .refill_data_i(refill_data_i),
    .refill_way_o(refill_way_o), .busy_o(busy_o), .tos2_valid_o(tos2_valid_o),
    .tos2_pc_o(tos2_pc_o), .tos2_data_o(tos2_data_o), .tos2_tag_o(tos2_tag_o),
    .tos2_vbit_o(tos2_vbit_o)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mkdata(input logic [21:0] t);
    return {4{10'd0, t}};
  endfunction

  function automatic logic [31:0] mkpc(input logic [21:0] t, input logic [5:0] s);
    return {t, s, 4'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_refill(input logic [5:0] s, input logic [21:0] t,
                           input logic [1:0] way_exp, input string tag);
    refill_valid_i = 1'b1;
    refill_set_i   = s;
    refill_tag_i   = t;
    refill_data_i  = mkdata(t);
    #1;
    chk(tag, 512'(refill_way_o), 512'(way_exp));
    tick();
    refill_valid_i = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] pc);
    pc_valid_i = 1'b1;
    pc_i       = pc;
    tick();
    pc_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; inv_i = 1'b0;
    pc_i = 32'd0; pc_valid_i = 1'b0;
    hit_valid_i = 1'b0; hit_set_i = 6'd0; hit_way_i = 2'd0;
    refill_valid_i = 1'b0; refill_set_i = 6'd0; refill_tag_i = 22'd0; refill_data_i = 128'd0;
    tick(); tick();
    chk("rst_valid", 512'(tos2_valid_o), 512'(1'b0));
    chk("rst_pc",    512'(tos2_pc_o),    512'(32'd0));
    chk("rst_busy",  512'(busy_o),       512'(1'b0));
    rst = 1'b0;
    #1;
    chk("rst_ready", 512'(pc_ready_o), 512'(1'b1));

    // 1: first read, empty set 4
    do_read(32'h1000_0040);
    chk("t1_valid", 512'(tos2_valid_o), 512'(1'b1));
    chk("t1_pc",    512'(tos2_pc_o),    512'(32'h1000_0040));
    chk("t1_vbit",  512'(tos2_vbit_o),  512'(4'b0000));
    tick();
    chk("t1_idle_valid", 512'(tos2_valid_o), 512'(1'b0));

    // 2: fill set 5, hit way 0, next victim is way 2
    do_refill(6'd5, TA, 2'd0, "t2_way_a");
    do_refill(6'd5, TB, 2'd1, "t2_way_b");
    do_refill(6'd5, TC, 2'd2, "t2_way_c");
    do_refill(6'd5, TD, 2'd3, "t2_way_d");
    hit_valid_i = 1'b1; hit_set_i = 6'd5; hit_way_i = 2'd0;
    tick();
    hit_valid_i = 1'b0;
    do_refill(6'd5, TE, 2'd2, "t2_way_e");
    do_read(mkpc(TA, 6'd5));
    chk("t2_vbit", 512'(tos2_vbit_o), 512'(4'b1111));
    chk("t2_tags", 512'(tos2_tag_o),  512'({TD, TE, TB, TA}));
    chk("t2_data2", 512'(tos2_data_o[2]), 512'(mkdata(TE)));

    // same-cycle refill (victim way 0) and hit way 3 on set 7 -> next victim way 1
    for (int w = 0; w < 4; w++) begin
      do_refill(6'd7, TA + 22'(w), 2'(w), "hr_fill");
    end
    hit_valid_i = 1'b1; hit_set_i = 6'd7; hit_way_i = 2'd3;
    do_refill(6'd7, TF, 2'd0, "hr_way_f");
    hit_valid_i = 1'b0;
    do_refill(6'd7, TE, 2'd1, "hr_way_next");

    // 3: stall three cycles with flush on the second
    do_read(mkpc(TB, 6'd5) | 32'h4);
    chk("t3_valid0", 512'(tos2_valid_o), 512'(1'b1));
    stall_i = 1'b1; pc_valid_i = 1'b1; pc_i = mkpc(TC, 6'd6);
    #1;
    chk("t3_ready", 512'(pc_ready_o), 512'(1'b0));
    tick();
    chk("t3_s1_valid", 512'(tos2_valid_o), 512'(1'b1));
    chk("t3_s1_pc",    512'(tos2_pc_o),    512'(mkpc(TB, 6'd5) | 32'h4));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t3_s2_valid", 512'(tos2_valid_o), 512'(1'b0));
    chk("t3_s2_pc",    512'(tos2_pc_o),    512'(mkpc(TB, 6'd5) | 32'h4));
    tick();
    chk("t3_s3_valid", 512'(tos2_valid_o), 512'(1'b0));
    chk("t3_s3_pc",    512'(tos2_pc_o),    512'(mkpc(TB, 6'd5) | 32'h4));
    stall_i = 1'b0;
    tick();
    pc_valid_i = 1'b0;
    chk("t3_rel_valid", 512'(tos2_valid_o), 512'(1'b1));
    chk("t3_rel_pc",    512'(tos2_pc_o),    512'(mkpc(TC, 6'd6)));

    // 4: read and refill of empty set 6 in the same cycle
    pc_valid_i = 1'b1; pc_i = mkpc(TF, 6'd6);
    do_refill(6'd6, TF, 2'd0, "t4_way");
    pc_valid_i = 1'b0;
`ifdef ICACHE_REFILL_FWD_EN
    chk("t4_vbit", 512'(tos2_vbit_o), 512'(4'b0001));
    chk("t4_tag0", 512'(tos2_tag_o[0]), 512'(TF));
`else
    chk("t4_vbit", 512'(tos2_vbit_o), 512'(4'b0000));
    chk("t4_tag0", 512'(tos2_tag_o[0]), 512'(22'd0));
`endif
    do_read(mkpc(TF, 6'd6));
    chk("t4_reread_vbit", 512'(tos2_vbit_o), 512'(4'b0001));
    chk("t4_reread_tag0", 512'(tos2_tag_o[0]), 512'(TF));

    // 5: invalidate walk; a repeated inv_i and a refill during the walk are ignored
    inv_i = 1'b1;
    tick();
    inv_i = 1'b0;
    chk("t5_ready", 512'(pc_ready_o), 512'(1'b0));
    pc_valid_i = 1'b1; pc_i = mkpc(TA, 6'd5);
    cnt = 0;
    while (busy_o && cnt < 200) begin
      chk("t5_walk_valid", 512'(tos2_valid_o), 512'(1'b0));
      inv_i = (cnt == 20);
      refill_valid_i = (cnt == 30); refill_set_i = 6'd9; refill_tag_i = TA;
      cnt++;
      tick();
    end
    inv_i = 1'b0; refill_valid_i = 1'b0;
    chk("t5_busy_cycles", 512'(cnt), 512'(64));
    chk("t5_exit_valid", 512'(tos2_valid_o), 512'(1'b0));
    tick();
    pc_valid_i = 1'b0;
    chk("t5_read_valid", 512'(tos2_valid_o), 512'(1'b1));
    chk("t5_read_vbit",  512'(tos2_vbit_o),  512'(4'b0000));
    do_read(mkpc(TA, 6'd9));
    chk("t5_drop_vbit", 512'(tos2_vbit_o), 512'(4'b0000));

    // 6: reset during the walk, then a full walk again
    do_refill(6'd40, TB, 2'd0, "t6_way");
    inv_i = 1'b1;
    tick();
    inv_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_mid_busy", 512'(busy_o), 512'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_busy",  512'(busy_o),       512'(1'b0));
    chk("t6_rst_valid", 512'(tos2_valid_o), 512'(1'b0));
    chk("t6_rst_pc",    512'(tos2_pc_o),    512'(32'd0));
    do_read(mkpc(TB, 6'd40));
    chk("t6_vbit40", 512'(tos2_vbit_o), 512'(4'b0000));
    inv_i = 1'b1;
    tick();
    inv_i = 1'b0;
    cnt = 0;
    while (busy_o && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("t6_busy_cycles", 512'(cnt), 512'(64));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
